// File: rtl/clock_meas.sv
// Measures high time, low time and period of a divided clock in clk_in cycles,
// publishes each full period with a valid strobe and flags lock/overflow.
module clock_meas #(
  parameter int CNT_W  = 8,
  parameter int LOCK_N = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             clk_mon,
  input  logic             clear,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period,
  output logic             meas_valid,
  output logic             locked,
  output logic             overflow
);

  localparam int MW = (LOCK_N > 2) ? $clog2(LOCK_N) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [MW-1:0]    MATCH_TOP = MW'(LOCK_N - 1);
  localparam logic [MW-1:0]    MATCH_ONE = MW'(1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  logic             m1_q, m2_q;
  logic             rise, fall;
  state_t           state_q;
  logic [CNT_W-1:0] hcnt_q, lcnt_q;
  logic [MW-1:0]    match_q;
  logic             have_prev_q;
  logic [CNT_W:0]   sum_d;
  logic             same_d;
  logic [MW-1:0]    match_d;
  logic             ovf_hit;

  // Sampler resets to "high/high" so a monitored clock that is already high at
  // release never looks like a rise; clear leaves it running for the same reason.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      m1_q <= 1'b1;
      m2_q <= 1'b1;
    end else begin
      m1_q <= clk_mon;
      m2_q <= m1_q;
    end
  end

  assign rise = m1_q & ~m2_q;
  assign fall = ~m1_q & m2_q;

  assign sum_d   = {1'b0, hcnt_q} + {1'b0, lcnt_q};
  assign same_d  = have_prev_q && (sum_d == period);
  assign match_d = !same_d ? '0 :
                   (match_q == MATCH_TOP) ? MATCH_TOP : match_q + MATCH_ONE;

  assign ovf_hit = ((state_q == HIGH) && m1_q && !fall && (hcnt_q == CNT_MAX)) ||
                   ((state_q == LOW) && !m1_q && !rise && (lcnt_q == CNT_MAX));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hcnt_q      <= '0;
      lcnt_q      <= '0;
      match_q     <= '0;
      have_prev_q <= 1'b0;
      high_cnt    <= '0;
      low_cnt     <= '0;
      period      <= '0;
      meas_valid  <= 1'b0;
      locked      <= 1'b0;
      overflow    <= 1'b0;
    end else if (clear) begin
      state_q     <= IDLE;
      hcnt_q      <= '0;
      lcnt_q      <= '0;
      match_q     <= '0;
      have_prev_q <= 1'b0;
      high_cnt    <= '0;
      low_cnt     <= '0;
      period      <= '0;
      meas_valid  <= 1'b0;
      locked      <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (ovf_hit) begin
        // Aborted period: published values hold, lock history is forgotten.
        overflow    <= 1'b1;
        locked      <= 1'b0;
        match_q     <= '0;
        have_prev_q <= 1'b0;
        hcnt_q      <= '0;
        lcnt_q      <= '0;
        state_q     <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (rise) begin
              hcnt_q  <= CNT_ONE;
              state_q <= HIGH;
            end
          end
          HIGH: begin
            if (fall) begin
              lcnt_q  <= CNT_ONE;
              state_q <= LOW;
            end else if (m1_q) begin
              hcnt_q <= hcnt_q + CNT_ONE;
            end
          end
          LOW: begin
            if (rise) begin
              high_cnt    <= hcnt_q;
              low_cnt     <= lcnt_q;
              period      <= sum_d;
              meas_valid  <= 1'b1;
              match_q     <= match_d;
              locked      <= (match_d == MATCH_TOP);
              have_prev_q <= 1'b1;
              hcnt_q      <= CNT_ONE;
              state_q     <= HIGH;
            end else if (!m1_q) begin
              lcnt_q <= lcnt_q + CNT_ONE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_meas.sv
// Directed bench for clock_meas: table of steady patterns plus hand-written
// sequences for lock, overflow, async reset and clear.
module tb_clock_meas;

  logic       clk_in;
  logic       rst_n;
  logic       clk_mon;
  logic       clear;
  logic [7:0] high_cnt;
  logic [7:0] low_cnt;
  logic [8:0] period;
  logic       meas_valid;
  logic       locked;
  logic       overflow;

  clock_meas #(.CNT_W(8), .LOCK_N(4)) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .clk_mon    (clk_mon),
    .clear      (clear),
    .high_cnt   (high_cnt),
    .low_cnt    (low_cnt),
    .period     (period),
    .meas_valid (meas_valid),
    .locked     (locked),
    .overflow   (overflow)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;

  // Publish log, filled on the falling edge.
  int n_valid  = 0;
  int cyc_cnt  = 0;
  int dbl_cnt  = 0;
  logic prev_valid = 1'b0;
  int log_h [0:127];
  int log_l [0:127];
  int log_p [0:127];
  int log_k [0:127];
  int log_t [0:127];

  always @(negedge clk_in) begin
    cyc_cnt = cyc_cnt + 1;
    if (meas_valid && prev_valid) dbl_cnt = dbl_cnt + 1;
    prev_valid = meas_valid;
    if (meas_valid) begin
      if (n_valid < 128) begin
        log_h[n_valid] = int'(high_cnt);
        log_l[n_valid] = int'(low_cnt);
        log_p[n_valid] = int'(period);
        log_k[n_valid] = int'(locked);
        log_t[n_valid] = cyc_cnt;
      end
      n_valid = n_valid + 1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks = n_checks + 1;
    if (act == exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic cyc(input logic v);
    clk_mon = v;
    @(negedge clk_in);
    #1;
  endtask

  task automatic run_pattern(input int h, input int l, input int r);
    for (int k = 0; k < r; k++) begin
      for (int i = 0; i < h; i++) cyc(1'b1);
      for (int i = 0; i < l; i++) cyc(1'b0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_high"},   int'(high_cnt),   0);
    chk({tag, "_low"},    int'(low_cnt),    0);
    chk({tag, "_period"}, int'(period),     0);
    chk({tag, "_valid"},  int'(meas_valid), 0);
    chk({tag, "_locked"}, int'(locked),     0);
    chk({tag, "_ovf"},    int'(overflow),   0);
  endtask

  typedef struct {
    int h; int l; int r;
    int e_hi; int e_lo; int e_per; int e_lock; int e_nv;
  } vec_t;

  vec_t tbl [0:4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    // {high, low, reps, exp high_cnt, low_cnt, period, locked, publishes}
    tbl[0] = '{8,  8,  6, 8,  8,  16, 1, 6};
    tbl[1] = '{14, 14, 5, 14, 14, 28, 1, 5};
    tbl[2] = '{3,  5,  6, 3,  5,  8,  1, 6};
    tbl[3] = '{3,  6,  4, 3,  6,  9,  0, 4};
    tbl[4] = '{3,  6,  1, 3,  6,  9,  1, 1};

    rst_n = 1'b0;
    clear = 1'b0;
    clk_mon = 1'b0;
    repeat (3) @(negedge clk_in);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (4) cyc(1'b0);

    // Divide-by-2: publish every 2 cycles, lock on the 4th publish.
    base = n_valid;
    run_pattern(1, 1, 6);
    chk("div2_count", n_valid - base, 5);
    chk("div2_high", log_h[base], 1);
    chk("div2_low", log_l[base], 1);
    chk("div2_period", log_p[base], 2);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("div2_lock%0d", k), log_k[base + k], (k >= 3) ? 1 : 0);
      if (k > 0) chk($sformatf("div2_gap%0d", k), log_t[base + k] - log_t[base + k - 1], 2);
    end
    $display("div2: %0d publishes, last %0d/%0d/%0d locked=%0d",
             n_valid - base, high_cnt, low_cnt, period, locked);

    for (int v = 0; v < 5; v++) begin
      base = n_valid;
      run_pattern(tbl[v].h, tbl[v].l, tbl[v].r);
      chk($sformatf("vec%0d_high", v),   int'(high_cnt), tbl[v].e_hi);
      chk($sformatf("vec%0d_low", v),    int'(low_cnt),  tbl[v].e_lo);
      chk($sformatf("vec%0d_period", v), int'(period),   tbl[v].e_per);
      chk($sformatf("vec%0d_locked", v), int'(locked),   tbl[v].e_lock);
      chk($sformatf("vec%0d_ovf", v),    int'(overflow), 0);
      chk($sformatf("vec%0d_count", v),  n_valid - base, tbl[v].e_nv);
      $display("vec%0d: h=%0d l=%0d x%0d -> %0d/%0d/%0d locked=%0d publishes=%0d",
               v, tbl[v].h, tbl[v].l, tbl[v].r, high_cnt, low_cnt, period,
               locked, n_valid - base);
    end

    // Stuck low: overflow once the low phase passes 255 cycles.
    base = n_valid;
    repeat (200) cyc(1'b0);
    chk("stuck_early_ovf", int'(overflow), 0);
    repeat (100) cyc(1'b0);
    chk("stuck_ovf", int'(overflow), 1);
    chk("stuck_locked", int'(locked), 0);
    chk("stuck_count", n_valid - base, 0);
    chk("stuck_high_hold", int'(high_cnt), 3);
    chk("stuck_low_hold", int'(low_cnt), 6);
    chk("stuck_period_hold", int'(period), 9);
    $display("stuck low: overflow=%0d locked=%0d", overflow, locked);

    base = n_valid;
    run_pattern(2, 2, 4);
    chk("resume_count", n_valid - base, 3);
    chk("resume_high", log_h[base], 2);
    chk("resume_low", log_l[base], 2);
    chk("resume_period", log_p[base], 4);
    chk("resume_locked", int'(locked), 0);
    chk("resume_ovf", int'(overflow), 1);
    $display("resume div4: %0d publishes, first %0d/%0d/%0d overflow=%0d",
             n_valid - base, log_h[base], log_l[base], log_p[base], overflow);

    // Async reset in the middle of a high phase.
    @(negedge clk_in);
    clk_mon = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    #1;
    rst_n = 1'b1;
    @(negedge clk_in);
    #1;
    cyc(1'b1);
    cyc(1'b0);
    cyc(1'b0);
    base = n_valid;
    run_pattern(2, 2, 3);
    chk("post_rst_count", n_valid - base, 2);
    chk("post_rst_high", log_h[base], 2);
    chk("post_rst_low", log_l[base], 2);
    chk("post_rst_period", log_p[base], 4);
    chk("post_rst_ovf", int'(overflow), 0);
    chk("post_rst_locked", int'(locked), 0);
    $display("after async reset: first %0d/%0d/%0d", log_h[base], log_l[base], log_p[base]);

    run_pattern(2, 2, 5);
    chk("pre_clear_locked", int'(locked), 1);

    // Synchronous clear while locked, then relock.
    clear = 1'b1;
    cyc(1'b0);
    clear = 1'b0;
    chk_all_zero("clear");
    base = n_valid;
    run_pattern(2, 2, 5);
    chk("relock_count", n_valid - base, 4);
    chk("relock_period", log_p[base], 4);
    chk("relock_lock3", log_k[base + 2], 0);
    chk("relock_lock4", log_k[base + 3], 1);
    $display("after clear: %0d publishes, locked=%0d", n_valid - base, locked);

    chk("single_cycle_valid", dbl_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
